// File: rtl/shift_pkg.sv
`default_nettype none
// ============================================================================
// Package  : shift_pkg
// Brief    : Shared mode encoding and datapath width for the shift command pipe.
// Revision : 1.0 - initial release
// ============================================================================
package shift_pkg;

    localparam int SHIFT_W = 4;

    typedef enum logic [1:0] {
        MODE_ROL = 2'b00,
        MODE_ROR = 2'b01,
        MODE_SLL = 2'b10,
        MODE_SRL = 2'b11
    } shift_mode_e;

endpackage
`default_nettype wire

// File: rtl/shift_sel_decode.sv
`default_nettype none
// ============================================================================
// Module   : shift_sel_decode
// Brief    : Builds the four source bits (d0..d3) feeding each output-bit mux slice.
// Revision : 1.0 - initial release
// ============================================================================
module shift_sel_decode
    import shift_pkg::*;
(
    input  logic [SHIFT_W-1:0]         data,
    input  shift_mode_e                mode,
    output logic [SHIFT_W*SHIFT_W-1:0] slice_in
);

    // slice_in[i*SHIFT_W + k] is the bit output i takes when the amount is k
    for (genvar i = 0; i < SHIFT_W; i++) begin : g_bit
        for (genvar k = 0; k < SHIFT_W; k++) begin : g_amt
            logic w_sll;
            logic w_srl;
            logic w_d;

            if (i >= k) begin : g_sll_src
                assign w_sll = data[i-k];
            end else begin : g_sll_zero
                assign w_sll = 1'b0;
            end

            if (i + k < SHIFT_W) begin : g_srl_src
                assign w_srl = data[i+k];
            end else begin : g_srl_zero
                assign w_srl = 1'b0;
            end

            always_comb begin
                w_d = 1'b0;
                case (mode)
                    MODE_ROL: w_d = data[(i - k + SHIFT_W) % SHIFT_W];
                    MODE_ROR: w_d = data[(i + k) % SHIFT_W];
                    MODE_SLL: w_d = w_sll;
                    MODE_SRL: w_d = w_srl;
                    default:  w_d = 1'b0;
                endcase
            end

            assign slice_in[i*SHIFT_W + k] = w_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/shift_cmd_pipe.sv
`default_nettype none
// ============================================================================
// Module   : shift_cmd_pipe
// Brief    : Two-stage valid/ready pipeline around the 4-bit barrel-shift mux network.
// Revision : 1.0 - initial release
// ============================================================================
module shift_cmd_pipe
    import shift_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [SHIFT_W-1:0] in_data,
    input  logic [1:0]         in_amt,
    input  logic [1:0]         in_mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [SHIFT_W-1:0] out_data,
    output logic               out_zero,
    output logic [CNT_W-1:0]   op_count
);

    logic                       r_s1_valid;
    logic [SHIFT_W-1:0]         r_s1_data;
    logic [1:0]                 r_s1_amt;
    shift_mode_e                r_s1_mode;

    logic                       r_out_valid;
    logic [SHIFT_W-1:0]         r_out_data;
    logic                       r_out_zero;
    logic [CNT_W-1:0]           r_op_count;

    logic                       w_s2_free;
    logic                       w_accept;
    logic                       w_advance;
    logic [SHIFT_W*SHIFT_W-1:0] w_slice_in;
    logic [SHIFT_W-1:0]         w_mux;

    assign w_s2_free = !r_out_valid || out_ready;
    assign in_ready  = !r_s1_valid || w_s2_free;
    assign w_accept  = in_valid && in_ready;
    assign w_advance = r_s1_valid && w_s2_free;

    shift_sel_decode u_sel_decode (
        .data     (r_s1_data),
        .mode     (r_s1_mode),
        .slice_in (w_slice_in)
    );

    // One 4:1 slice per output bit, all steered by the registered amount
    for (genvar i = 0; i < SHIFT_W; i++) begin : g_slice
        logic w_bit;

        always_comb begin
            w_bit = 1'b0;
            case (r_s1_amt)
                2'd0:    w_bit = w_slice_in[i*SHIFT_W + 0];
                2'd1:    w_bit = w_slice_in[i*SHIFT_W + 1];
                2'd2:    w_bit = w_slice_in[i*SHIFT_W + 2];
                2'd3:    w_bit = w_slice_in[i*SHIFT_W + 3];
                default: w_bit = 1'b0;
            endcase
        end

        assign w_mux[i] = w_bit;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_data  <= '0;
            r_s1_amt   <= '0;
            r_s1_mode  <= MODE_ROL;
        end else if (w_accept) begin
            r_s1_valid <= 1'b1;
            r_s1_data  <= in_data;
            r_s1_amt   <= in_amt;
            r_s1_mode  <= shift_mode_e'(in_mode);
        end else if (w_advance) begin
            r_s1_valid <= 1'b0;
        end
    end

    // S2 data only moves on advance so the result holds steady under backpressure
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_zero  <= 1'b1;
        end else if (w_advance) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_mux;
            r_out_zero  <= (w_mux == '0);
        end else if (w_s2_free) begin
            r_out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op_count <= '0;
        end else if (w_accept) begin
            r_op_count <= r_op_count + CNT_W'(1);
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_zero  = r_out_zero;
    assign op_count  = r_op_count;

endmodule
`default_nettype wire

// File: tb/tb_shift_cmd_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_shift_cmd_pipe
// Brief    : Self-checking bench for shift_cmd_pipe against a behavioural shift model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_shift_cmd_pipe;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_data;
    logic [1:0] in_amt;
    logic [1:0] in_mode;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_data;
    logic       out_zero;
    logic [7:0] op_count;

    int n_checks  = 0;
    int n_fail    = 0;
    int exp_count = 0;

    always #5 clk = ~clk;

    shift_cmd_pipe #(.CNT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_amt    (in_amt),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_zero  (out_zero),
        .op_count  (op_count)
    );

    // Rotates use a doubled word; shifts use native 4-bit truncation
    function automatic logic [3:0] ref_shift(logic [3:0] d, logic [1:0] a, logic [1:0] m);
        logic [7:0] dd;
        logic [3:0] t;
        dd = {d, d};
        case (m)
            2'b00:   begin dd = dd << a; t = dd[7:4]; end
            2'b01:   begin dd = dd >> a; t = dd[3:0]; end
            2'b10:   t = d << a;
            default: t = d >> a;
        endcase
        return t;
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_amt = '0; in_mode = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_checks++; if (out_data !== 4'b0000) begin n_fail++; $display("FAIL reset_out_data: got %b want 0000", out_data); end
        n_checks++; if (out_zero !== 1'b1) begin n_fail++; $display("FAIL reset_out_zero: got %b want 1", out_zero); end
        n_checks++; if (op_count !== 8'd0) begin n_fail++; $display("FAIL reset_op_count: got %0d want 0", op_count); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        exp_count = 0;
    endtask

    task automatic test_modes();
        logic [3:0] t_d [9] = '{4'b1011, 4'b1011, 4'b1011, 4'b1011, 4'b0110, 4'b0110, 4'b0110, 4'b0110, 4'b1000};
        logic [1:0] t_a [9] = '{2'd1, 2'd1, 2'd2, 2'd3, 2'd0, 2'd0, 2'd0, 2'd0, 2'd3};
        logic [1:0] t_m [9] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00, 2'b01, 2'b10, 2'b11, 2'b10};
        logic [3:0] t_e [9] = '{4'b0111, 4'b1101, 4'b1100, 4'b0001, 4'b0110, 4'b0110, 4'b0110, 4'b0110, 4'b0000};
        for (int n = 0; n < 9; n++) begin
            next_cycle();
            in_valid = 1'b1; in_data = t_d[n]; in_amt = t_a[n]; in_mode = t_m[n]; out_ready = 1'b1;
            #1;
            n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL mode%0d_in_ready: got %b want 1", n, in_ready); end
            next_cycle();
            in_valid = 1'b0;
            exp_count++;
            #1;
            n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mode%0d_early_valid: got %b want 0", n, out_valid); end
            next_cycle();
            #1;
            n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL mode%0d_latency: got out_valid %b want 1", n, out_valid); end
            n_checks++; if (out_data !== t_e[n]) begin n_fail++; $display("FAIL mode%0d_data: got %b want %b", n, out_data, t_e[n]); end
            n_checks++; if (out_zero !== (t_e[n] == 4'b0000)) begin n_fail++; $display("FAIL mode%0d_zero: got %b want %b", n, out_zero, (t_e[n] == 4'b0000)); end
            next_cycle();
            #1;
            n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mode%0d_valid_fall: got %b want 0", n, out_valid); end
        end
        n_checks++; if (op_count !== 8'(exp_count)) begin n_fail++; $display("FAIL modes_op_count: got %0d want %0d", op_count, 8'(exp_count)); end
    endtask

    task automatic test_back_to_back();
        logic [3:0] d [8];
        logic [1:0] a [8];
        logic [1:0] m [8];
        logic [3:0] e;
        for (int n = 0; n < 8; n++) begin
            d[n] = 4'($urandom); a[n] = 2'($urandom); m[n] = 2'($urandom);
        end
        for (int t = 0; t < 10; t++) begin
            next_cycle();
            out_ready = 1'b1;
            if (t < 8) begin
                in_valid = 1'b1; in_data = d[t]; in_amt = a[t]; in_mode = m[t];
                exp_count++;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (t < 8) begin
                n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready t%0d: got %b want 1", t, in_ready); end
            end
            n_checks++; if (out_valid !== (t >= 2)) begin n_fail++; $display("FAIL b2b_out_valid t%0d: got %b want %b", t, out_valid, (t >= 2)); end
            if (t >= 2) begin
                e = ref_shift(d[t-2], a[t-2], m[t-2]);
                n_checks++; if (out_data !== e) begin n_fail++; $display("FAIL b2b_data t%0d: got %b want %b", t, out_data, e); end
            end
        end
        n_checks++; if (op_count !== 8'(exp_count)) begin n_fail++; $display("FAIL b2b_op_count: got %0d want %0d", op_count, 8'(exp_count)); end
        next_cycle();
    endtask

    task automatic test_backpressure();
        logic [3:0] d [3];
        logic [1:0] a [3];
        logic [1:0] m [3];
        logic [3:0] e [3];
        for (int n = 0; n < 3; n++) begin
            d[n] = 4'($urandom); a[n] = 2'($urandom); m[n] = 2'($urandom);
            e[n] = ref_shift(d[n], a[n], m[n]);
        end
        for (int c = 0; c < 8; c++) begin
            next_cycle();
            out_ready = (c >= 4);
            in_valid  = (c <= 4);
            if (c <= 2) begin
                in_data = d[c]; in_amt = a[c]; in_mode = m[c];
            end
            #1;
            case (c)
                0, 1: begin
                    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_in_ready c%0d: got %b want 1", c, in_ready); end
                    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_out_valid c%0d: got %b want 0", c, out_valid); end
                end
                2, 3: begin
                    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready_low c%0d: got %b want 0", c, in_ready); end
                    n_checks++; if (out_valid !== 1'b1 || out_data !== e[0]) begin n_fail++; $display("FAIL bp_hold c%0d: got valid %b data %b want 1 %b", c, out_valid, out_data, e[0]); end
                end
                4: begin
                    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready: got %b want 1", in_ready); end
                    n_checks++; if (out_valid !== 1'b1 || out_data !== e[0]) begin n_fail++; $display("FAIL bp_first: got valid %b data %b want 1 %b", out_valid, out_data, e[0]); end
                end
                5, 6: begin
                    n_checks++; if (out_valid !== 1'b1 || out_data !== e[c-4]) begin n_fail++; $display("FAIL bp_order c%0d: got valid %b data %b want 1 %b", c, out_valid, out_data, e[c-4]); end
                end
                default: begin
                    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain: got %b want 0", out_valid); end
                end
            endcase
        end
        exp_count += 3;
        n_checks++; if (op_count !== 8'(exp_count)) begin n_fail++; $display("FAIL bp_op_count: got %0d want %0d", op_count, 8'(exp_count)); end
    endtask

    task automatic test_reset_mid();
        for (int c = 0; c < 2; c++) begin
            next_cycle();
            out_ready = 1'b0; in_valid = 1'b1;
            in_data = 4'($urandom) | 4'b0001; in_amt = 2'd0; in_mode = 2'($urandom);
        end
        next_cycle();
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_out_valid: got %b want 0", out_valid); end
        n_checks++; if (out_data !== 4'b0000) begin n_fail++; $display("FAIL rstmid_out_data: got %b want 0000", out_data); end
        n_checks++; if (out_zero !== 1'b1) begin n_fail++; $display("FAIL rstmid_out_zero: got %b want 1", out_zero); end
        n_checks++; if (op_count !== 8'd0) begin n_fail++; $display("FAIL rstmid_op_count: got %0d want 0", op_count); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_in_ready: got %b want 1", in_ready); end
        exp_count = 0;
        next_cycle();
        rst = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            next_cycle();
            n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_stale c%0d: got out_valid %b want 0", c, out_valid); end
        end
    endtask

    task automatic test_count_wrap();
        for (int c = 0; c < 256; c++) begin
            next_cycle();
            out_ready = 1'b1; in_valid = 1'b1;
            in_data = 4'($urandom); in_amt = 2'($urandom); in_mode = 2'($urandom);
            #1;
            if (c == 255) begin
                n_checks++; if (op_count !== 8'd255) begin n_fail++; $display("FAIL wrap_pre: got %0d want 255", op_count); end
            end
            if (in_ready) exp_count++;
        end
        next_cycle();
        in_valid = 1'b0;
        #1;
        n_checks++; if (op_count !== 8'd0) begin n_fail++; $display("FAIL wrap_zero: got %0d want 0", op_count); end
        exp_count = exp_count % 256;
        repeat (3) next_cycle();
    endtask

    task automatic test_random();
        logic [3:0] q[$];
        logic [3:0] e;
        logic       prev_stall = 1'b0;
        logic [3:0] prev_data  = '0;
        logic       exp_ready;
        for (int c = 0; c < 500; c++) begin
            next_cycle();
            in_valid  = ($urandom_range(0, 9) < 7);
            in_data   = 4'($urandom); in_amt = 2'($urandom); in_mode = 2'($urandom);
            out_ready = ($urandom_range(0, 9) < 6);
            #1;
            exp_ready = !(q.size() == 2 && !out_ready);
            n_checks++; if (in_ready !== exp_ready) begin n_fail++; $display("FAIL rnd_in_ready c%0d: got %b want %b", c, in_ready, exp_ready); end
            if (prev_stall) begin
                n_checks++; if (out_valid !== 1'b1 || out_data !== prev_data) begin n_fail++; $display("FAIL rnd_stable c%0d: got valid %b data %b want 1 %b", c, out_valid, out_data, prev_data); end
            end
            if (out_valid) begin
                n_checks++; if (q.size() == 0) begin n_fail++; $display("FAIL rnd_spurious c%0d: got out_valid 1 want 0", c); end
            end
            if (out_valid && out_ready && q.size() > 0) begin
                e = q.pop_front();
                n_checks++; if (out_data !== e || out_zero !== (e == 4'b0000)) begin n_fail++; $display("FAIL rnd_data c%0d: got %b/%b want %b/%b", c, out_data, out_zero, e, (e == 4'b0000)); end
            end
            if (in_valid && in_ready) begin
                q.push_back(ref_shift(in_data, in_amt, in_mode));
                exp_count++;
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
        end
        next_cycle();
        in_valid = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            #1;
            if (out_valid && q.size() > 0) begin
                e = q.pop_front();
                n_checks++; if (out_data !== e) begin n_fail++; $display("FAIL rnd_drain c%0d: got %b want %b", c, out_data, e); end
            end
            next_cycle();
        end
        n_checks++; if (q.size() != 0) begin n_fail++; $display("FAIL rnd_lost: got %0d results missing want 0", q.size()); end
        n_checks++; if (op_count !== 8'(exp_count)) begin n_fail++; $display("FAIL rnd_op_count: got %0d want %0d", op_count, 8'(exp_count)); end
    endtask

    initial begin
        test_reset();
        test_modes();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        test_count_wrap();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
